fft_pingpong_ram: RTL
=====================

Name: fft_pingpong_ram

Overview:
- Parametrised successor to the FFT coefficient/sample single-port SRAM.
- Two banks of 2^ADDR_W words in ping-pong arrangement: the input stage writes the "fill" bank while the butterfly stage reads the "active" bank in the same cycle.
- Swapped on command at FFT frame boundaries.
- Read latency is configurable, and reads are tracked by a valid flag.

Parameters:
- DATA_W, 41, word width in bits (signed complex-packed sample).
- ADDR_W, 11, address width; each bank holds 2^ADDR_W words.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select; when low, wr_en, rd_en and swap_req are ignored.
- wr_en  in  1  write strobe to the fill bank.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe from the active bank.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data carries a result this cycle.
- swap_req  in  1  one-cycle pulse; exchange the fill and active banks.
- bank_sel  out  1  index of the active (read) bank; the fill bank is ~bank_sel.

Behaviour:
- Reset (rst high, asynchronous):
  - rd_data=0, rd_valid=0, bank_sel=0, read pipeline flushed.
  - Memory contents are not cleared and are undefined after power-up.
  - Deassertion is sampled on a clk edge.
- Write: at the edge with cs&wr_en, mem[~bank_sel][wr_addr] <= wr_data. No write strobes, always full-word.
- Read with READ_LAT=1: at the edge with cs&rd_en, rd_data <= mem[bank_sel][rd_addr] and rd_valid<=1.
- Read with READ_LAT=2: the bank output is registered once more; rd_data/rd_valid appear one cycle later.
- Idle cycles: rd_valid deasserts the cycle after no read was issued (per pipeline stage). rd_data holds its last value when not valid.
- Swap: at the edge with cs&swap_req, bank_sel toggles.
  - Reads issued in the same cycle or earlier use the pre-swap bank_sel and complete from the old active bank; the bank index is captured at issue.
  - A write in the swap cycle lands in the pre-swap fill bank, i.e. the bank that becomes active. A read of that address in the next cycle returns the new data.
- Read/write collision: read and write always target different banks in a given cycle, so no bypass is needed and simultaneous wr_en and rd_en at the same address are legal.
- cs low: no memory access and no swap. In-flight reads still drain and raise rd_valid on schedule.
- Back-to-back reads: one per cycle, full throughput, in order.
- Addresses wrap naturally at 2^ADDR_W; no out-of-range case exists.
- Reset mid-read: the in-flight result is discarded, rd_valid=0 immediately (asynchronously), and bank_sel returns to 0.

Decomposition:
- Package fft_mem_pkg holds:
  - DATA_W and ADDR_W defaults.
  - typedefs fft_word_t (signed [DATA_W-1:0]) and fft_addr_t.
  - localparam DEPTH=2**ADDR_W.
- Sub-module fft_ram_bank: simple dual-port RAM with one write and one read port, 1-cycle registered read, no reset on the array.
- The top instantiates fft_ram_bank twice and adds:
  - bank steering;
  - bank_sel register;
  - captured bank index for read-data mux selection;
  - optional second output stage;
  - rd_valid shift register.

Test Plan:
1. Reset then fill: assert rst 3 cycles, check rd_data=0, rd_valid=0, bank_sel=0. Write addr 0..7 = 0x100+i to the fill bank (bank 1), pulse swap_req. bank_sel=1, then reading addr 5 returns 0x105 with rd_valid after READ_LAT cycles.
2. Concurrent access: with bank_sel=1, write addr 5=0x1AAAA to bank 0 while reading addr 5 the same cycle. Read returns 0x105. After a swap, addr 5 reads 0x1AAAA.
3. Swap during read: issue read addr 3 in the same cycle as swap_req. Returns the old-bank value 0x103, and the next read of addr 3 returns the other bank's data.
4. cs gating: with cs=0, drive wr_en, rd_en and swap_req. No rd_valid, bank_sel unchanged, and a later read shows the memory unmodified.
5. Throughput and latency: stream reads addr 0..2047 back-to-back for READ_LAT=1 and 2. rd_valid is continuous, data is in order, and the first valid is exactly READ_LAT cycles after the first rd_en. Also check a sign-extended negative value (0x1_0000_0000_00) round-trips.
6. Async reset mid-stream: assert rst between clock edges during a read burst. rd_valid and rd_data go to 0 without waiting for clk, bank_sel=0, and no stale valid follows deassertion.

Source files
------------

// File: rtl/fft_mem_pkg.sv
// Shared widths and types for the FFT ping-pong sample memory.
package fft_mem_pkg;
  localparam int FFT_DATA_W = 41;
  localparam int FFT_ADDR_W = 11;
  localparam int DEPTH      = 2 ** FFT_ADDR_W;

  typedef logic signed [FFT_DATA_W-1:0] fft_word_t;
  typedef logic        [FFT_ADDR_W-1:0] fft_addr_t;
endpackage

// File: rtl/fft_pingpong_ram_if.sv
// Access bus of the ping-pong memory: write port, read port, swap control.
interface fft_pingpong_ram_if #(
  parameter int DATA_W = 41,
  parameter int ADDR_W = 11
);
  logic                     cs;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     swap_req;
  logic                     bank_sel;

  modport master (
    output cs, wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
    input  rd_data, rd_valid, bank_sel
  );

  modport slave (
    input  cs, wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
    output rd_data, rd_valid, bank_sel
  );
endinterface

// File: rtl/fft_ram_bank.sv
// Simple dual-port RAM bank: one write port, one read port with registered output.
module fft_ram_bank #(
  parameter int DATA_W = 41,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic        [ADDR_W-1:0] waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic        [ADDR_W-1:0] raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [2**ADDR_W];

  // The array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong memory: input stage fills one bank while the butterfly reads the other.
module fft_pingpong_ram
  import fft_mem_pkg::*;
#(
  parameter int DATA_W   = FFT_DATA_W,
  parameter int ADDR_W   = FFT_ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft_pingpong_ram_if.slave bus
);
  logic                     rd_issue, wr_issue, swap_issue;
  logic                     bank_sel;
  logic signed [DATA_W-1:0] q0, q1;
  logic                     rd_bank_p0;
  logic                     vld_p0;
  logic                     loaded_p0;
  logic signed [DATA_W-1:0] q_p0;

  assign rd_issue   = bus.cs & bus.rd_en;
  assign wr_issue   = bus.cs & bus.wr_en;
  assign swap_issue = bus.cs & bus.swap_req;

  // Writes go to the fill bank (~bank_sel); reads come from the active bank.
  fft_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_issue & bank_sel),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .re    (rd_issue & ~bank_sel),
    .raddr (bus.rd_addr),
    .rdata (q0)
  );

  fft_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_issue & ~bank_sel),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .re    (rd_issue & bank_sel),
    .raddr (bus.rd_addr),
    .rdata (q1)
  );

  // Stage p0: bank index captured at issue, so a read racing a swap finishes from the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel   <= 1'b0;
      rd_bank_p0 <= 1'b0;
      vld_p0     <= 1'b0;
      loaded_p0  <= 1'b0;
    end else begin
      if (swap_issue) bank_sel <= ~bank_sel;
      vld_p0 <= rd_issue;
      if (rd_issue) begin
        rd_bank_p0 <= bank_sel;
        loaded_p0  <= 1'b1;
      end
    end
  end

  // The bank registers have no reset; loaded_p0 forces zero until a read has landed.
  assign q_p0 = loaded_p0 ? (rd_bank_p0 ? q1 : q0) : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic signed [DATA_W-1:0] rd_data_p1;
      logic                     vld_p1;

      // Stage p1: extra output register for timing closure.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rd_data_p1 <= q_p0;
        end
      end

      assign bus.rd_data  = rd_data_p1;
      assign bus.rd_valid = vld_p1;
    end else begin : g_lat1
      assign bus.rd_data  = q_p0;
      assign bus.rd_valid = vld_p0;
    end
  endgenerate

  assign bus.bank_sel = bank_sel;
endmodule
